idct_row_sched: RTL

IDCT_ROW_SCHED -- requirements
Module: idct_row_sched

---
 rtl/idct_row_sched_if.sv | 31 +++
 rtl/idct_row_sched.sv | 96 +++++++++
 2 files changed

// File: rtl/idct_row_sched_if.sv
// idct_row_sched_if -- bus bundle for the IDCT row scheduler.
//   in_valid/in_ready/in_coef    : coefficient input handshake (row-major block order)
//   row_vec/row_res              : loop to the external combinational row-IDCT datapath
//   col_valid/col_ready/col_data : intermediate column output handshake
//   col_idx                      : index of the column on col_data
//   blk_done                     : pulse on acceptance of the last column of a block
//   busy                         : a block is in progress
// slave  = scheduler view, master = environment view.
interface idct_row_sched_if;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_coef;
    logic [255:0] row_vec;
    logic [255:0] row_res;
    logic         col_valid;
    logic         col_ready;
    logic [255:0] col_data;
    logic [2:0]   col_idx;
    logic         blk_done;
    logic         busy;

    modport slave (
        input  in_valid, in_coef, row_res, col_ready,
        output in_ready, row_vec, col_valid, col_data, col_idx, blk_done, busy
    );

    modport master (
        output in_valid, in_coef, row_res, col_ready,
        input  in_ready, row_vec, col_valid, col_data, col_idx, blk_done, busy
    );
endinterface

// File: rtl/idct_row_sched.sv
// idct_row_sched -- single-buffered 8x8 row-pass scheduler for a 2-D IDCT.
// Collects 8 coefficients into a row register (LOAD), captures the external
// row-IDCT result into an 8x8 buffer (ROW), and after 8 rows streams the
// buffer out column by column (DRAIN).
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : idct_row_sched_if.slave (see interface header for signal roles)
module idct_row_sched (
    input  logic               clk,
    input  logic               rst,
    idct_row_sched_if.slave    bus
);
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ROW   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [2:0]             coef_cnt_q, coef_cnt_d;
    logic [2:0]             row_cnt_q, row_cnt_d;
    logic [2:0]             col_cnt_q, col_cnt_d;
    logic [7:0][31:0]       row_q, row_d;
    // blk_q[r][c]: row r, column c of the row-transformed block
    logic [7:0][7:0][31:0]  blk_q, blk_d;
    logic [7:0][31:0]       col_w;

    always_comb begin
        state_d       = state_q;
        coef_cnt_d    = coef_cnt_q;
        row_cnt_d     = row_cnt_q;
        col_cnt_d     = col_cnt_q;
        row_d         = row_q;
        blk_d         = blk_q;
        bus.in_ready  = 1'b0;
        bus.col_valid = 1'b0;
        bus.blk_done  = 1'b0;
        case (state_q)
            LOAD: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    row_d[coef_cnt_q] = bus.in_coef;
                    coef_cnt_d        = coef_cnt_q + 3'd1;
                    if (coef_cnt_q == 3'd7) state_d = ROW;
                end
            end
            ROW: begin
                blk_d[row_cnt_q] = bus.row_res;
                row_cnt_d        = row_cnt_q + 3'd1;
                state_d          = (row_cnt_q == 3'd7) ? DRAIN : LOAD;
            end
            DRAIN: begin
                bus.col_valid = 1'b1;
                if (bus.col_ready) begin
                    col_cnt_d = col_cnt_q + 3'd1;
                    if (col_cnt_q == 3'd7) begin
                        bus.blk_done = 1'b1;
                        state_d      = LOAD;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Column view of the buffer; only col_cnt_q selects, so it is stable under stall.
    always_comb begin
        for (int r = 0; r < 8; r++) col_w[r] = blk_q[r][col_cnt_q];
    end

    assign bus.row_vec  = row_q;
    assign bus.col_data = col_w;
    assign bus.col_idx  = col_cnt_q;
    // Idle only when sitting in LOAD with nothing of the block accepted yet.
    assign bus.busy     = !(state_q == LOAD && coef_cnt_q == 3'd0 && row_cnt_q == 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD;
            coef_cnt_q <= 3'd0;
            row_cnt_q  <= 3'd0;
            col_cnt_q  <= 3'd0;
        end else begin
            state_q    <= state_d;
            coef_cnt_q <= coef_cnt_d;
            row_cnt_q  <= row_cnt_d;
            col_cnt_q  <= col_cnt_d;
        end
    end

    // Datapath storage carries no reset; contents are always rewritten before use.
    always_ff @(posedge clk) begin
        row_q <= row_d;
        blk_q <= blk_d;
    end
endmodule
